param_link_tx: RTL

Serialises oscillator parameter updates into the byte-plus-strobe stream consumed by the synth's parameter decoder (`i_data` / `i_data_load`). It sits between the control/UI logic and the decoder. It accepts one parameter write at a time over a valid/ready handshake, then emits the frame: opcode byte, data bytes LSB-first, and a trailer byte that commits the value. Strobe setup and high times are programmable so the decoder's rising-edge capture always sees stable data.

---
 rtl/synth_link_pkg.sv | 41 ++++
 rtl/byte_strobe_gen.sv | 49 ++++
 rtl/param_link_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/synth_link_pkg.sv
// rtl/synth_link_pkg.sv - shared parameter-link definitions for encoder and decoder
package synth_link_pkg;

    typedef enum logic [1:0] {
        WAVE  = 2'd0,
        FREQ  = 2'd1,
        PHASE = 2'd2,
        AMP   = 2'd3
    } param_e;

    localparam logic [7:0] OSC1_BASE = 8'h00;
    localparam logic [7:0] OSC2_BASE = 8'h10;
    localparam logic [7:0] TRAILER   = 8'h00;

    function automatic logic [2:0] param_nbytes(input param_e param);
        case (param)
            WAVE:    param_nbytes = 3'd1;
            FREQ:    param_nbytes = 3'd3;
            default: param_nbytes = 3'd2;
        endcase
    endfunction

    // Byte idx of a frame: 0 = opcode, 1..N = value LSB-first, N+1 = trailer.
    function automatic logic [7:0] frame_byte(input logic osc, input param_e param,
                                              input logic [23:0] value, input logic [2:0] idx);
        logic [2:0] code;
        code = {1'b0, param} + 3'd1;
        if (idx == 3'd0) begin
            frame_byte = (osc ? OSC2_BASE : OSC1_BASE) | {5'b00000, code};
        end else if (idx > param_nbytes(param)) begin
            frame_byte = TRAILER;
        end else begin
            case (idx)
                3'd1:    frame_byte = value[7:0];
                3'd2:    frame_byte = value[15:8];
                default: frame_byte = value[23:16];
            endcase
        end
    endfunction

endpackage

// File: rtl/byte_strobe_gen.sv
// rtl/byte_strobe_gen.sv - setup/strobe phase timer for one byte on the parameter link
module byte_strobe_gen #(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_byte_valid,
    output logic o_data_load,
    output logic o_strobe_start,
    output logic o_byte_done
);

    localparam int MAX_CYC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic          active;
    logic          strobe;
    logic [CW-1:0] cnt;

    assign o_data_load    = strobe;
    assign o_strobe_start = active && !strobe && (cnt == CW'(SETUP_CYCLES - 1));
    assign o_byte_done    = active && strobe && (cnt == CW'(STROBE_CYCLES - 1));

    // A new byte pulse wins over the end of the previous strobe so bytes chain without a gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active <= 1'b0;
            strobe <= 1'b0;
            cnt    <= '0;
        end else if (i_byte_valid) begin
            active <= 1'b1;
            strobe <= 1'b0;
            cnt    <= '0;
        end else if (active) begin
            if (o_strobe_start) begin
                strobe <= 1'b1;
                cnt    <= '0;
            end else if (o_byte_done) begin
                active <= 1'b0;
                strobe <= 1'b0;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/param_link_tx.sv
// rtl/param_link_tx.sv - serialises oscillator parameter writes into byte-plus-strobe frames
module param_link_tx
    import synth_link_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_osc,
    input  logic [1:0]  i_req_param,
    input  logic [23:0] i_req_value,
    output logic [7:0]  o_data,
    output logic        o_data_load,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_e;

    state_e      state;
    state_e      state_nxt;
    logic        osc_q;
    param_e      param_q;
    logic [23:0] value_q;
    logic [2:0]  idx;
    logic        accept;
    logic        last_byte;
    logic        byte_valid;
    logic        strobe_start;
    logic        byte_done;

    assign accept     = i_req_valid && (state == IDLE);
    assign last_byte  = (idx == param_nbytes(param_q) + 3'd1);
    assign byte_valid = accept || ((state == STROBE) && byte_done && !last_byte);

    byte_strobe_gen #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES)
    ) u_strobe (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_byte_valid   (byte_valid),
        .o_data_load    (o_data_load),
        .o_strobe_start (strobe_start),
        .o_byte_done    (byte_done)
    );

    // o_data is only reloaded on the edge that opens a new SETUP phase or enters DONE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            osc_q   <= 1'b0;
            param_q <= WAVE;
            value_q <= '0;
            idx     <= '0;
            o_data  <= 8'h00;
        end else begin
            state <= state_nxt;
            if (accept) begin
                osc_q   <= i_req_osc;
                param_q <= param_e'(i_req_param);
                value_q <= i_req_value;
                idx     <= 3'd0;
                o_data  <= frame_byte(i_req_osc, param_e'(i_req_param), i_req_value, 3'd0);
            end else if ((state == STROBE) && byte_done) begin
                if (last_byte) begin
                    o_data <= TRAILER;
                end else begin
                    idx    <= idx + 3'd1;
                    o_data <= frame_byte(osc_q, param_q, value_q, idx + 3'd1);
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        o_req_ready = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                o_busy      = 1'b0;
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                if (strobe_start) state_nxt = STROBE;
            end
            STROBE: begin
                if (byte_done) state_nxt = last_byte ? DONE : SETUP;
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
